// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus borrow flop, LSB first.
// Optional SERIAL_SUB_BORROW_IN_EN adds a borrow-in port (bin) seeding the borrow flop.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             barrow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic bin_w;
  logic d_bit;
  logic bo_bit;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign bin_w = bin;
`else
  assign bin_w = 1'b0;
`endif

  assign d_bit  = ra_q[0] ^ rb_q[0] ^ bor_q;
  assign bo_bit = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & bor_q);

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          bor_d   = bin_w;
          cnt_d   = '0;
          res_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        bor_d = bo_bit;
        cnt_d = CW'(cnt_q + 1'b1);
        // Final bit: publish the shifted-in result directly so difference lands with done.
        if (cnt_q == LAST) begin
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bout_d  = bo_bit;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign difference = diff_q;
  assign barrow     = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results, monitor pops on done.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, barrow;
  logic [WIDTH-1:0] difference;
`ifdef SERIAL_SUB_BORROW_IN_EN
  logic             bin;
`endif

  int nvec = 0;
  int nerr = 0;
  logic [WIDTH:0] exp_q[$];

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .bin        (bin),
`endif
    .busy       (busy),
    .done       (done),
    .difference (difference),
    .barrow     (barrow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: unsigned subtraction one bit wider; the extra top bit is the borrow out.
  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic bi);
    logic [WIDTH:0] r;
    r = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, bi};
    return r;
  endfunction

  // Monitor: compares on done, otherwise checks the registered outputs hold still.
  initial begin
    logic [WIDTH:0] held;
    logic [WIDTH:0] e;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = '0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'({barrow, difference}), 32'(e));
        end
        held = {barrow, difference};
      end else begin
        check("hold", 32'({barrow, difference}), 32'(held));
      end
    end
  end

  task automatic op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic bi,
                    input bit inject);
    int cycles;
    int busycnt;
    start = 1'b1;
    a     = x;
    b     = y;
`ifdef SERIAL_SUB_BORROW_IN_EN
    bin   = bi;
    exp_q.push_back(model(x, y, bi));
`else
    exp_q.push_back(model(x, y, 1'b0));
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    cycles  = 0;
    busycnt = busy ? 1 : 0;
    while (!done && cycles < WIDTH + 4) begin
      if (inject && cycles == 3) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (busy) busycnt++;
    end
    start = 1'b0;
    check("latency", cycles, WIDTH);
    check("busy_cycles", busycnt, WIDTH);
    @(posedge clk);
    #1;
    check("done_single", {30'd0, busy, done}, 0);
  endtask

  initial begin
    int donecnt;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int donecnt;
    int lastk;
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SERIAL_SUB_BORROW_IN_EN
    bin   = 1'b0;
`endif
    #12;
    check("reset_outputs", 32'({busy, done, barrow, difference}), 0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    op(8'h05, 8'h03, 1'b0, 1'b0);
    op(8'h03, 8'h05, 1'b0, 1'b0);
    op(8'hFF, 8'h00, 1'b0, 1'b0);
    op(8'h00, 8'h00, 1'b0, 1'b0);
    op(8'h10, 8'h01, 1'b0, 1'b1);

    // Asynchronous abort four cycles into an operation.
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_reset", 32'({busy, done, barrow, difference}), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_no_done", {31'd0, done}, 0);
    op(8'h80, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_SUB_BORROW_IN_EN
    op(8'h05, 8'h03, 1'b1, 1'b0);
    op(8'h00, 8'h00, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 24; i++)
      op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);

    // Start held high: accepted every WIDTH+2 clocks.
    for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h09, 8'h04, 1'b0));
`ifdef SERIAL_SUB_BORROW_IN_EN
    bin = 1'b0;
`endif
    a = 8'h09;
    b = 8'h04;
    start = 1'b1;
    donecnt = 0;
    lastk = -1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        if (donecnt == 0) check("b2b_first", k, WIDTH);
        else check("b2b_spacing", k - lastk, WIDTH + 2);
        donecnt++;
        lastk = k;
      end
    end
    start = 1'b0;
    check("b2b_count", donecnt, 3);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
